// File: rtl/dmem_mmio.sv
// dmem_mmio
// ---------
// Data memory plus memory-mapped I/O behind the MIPS core's memory stage.
// Each word-aligned address selects one target:
//   addr < RAM_WORDS*4  word RAM: asynchronous read, write at the clock edge
//   0xFFFF0000 COUNT    free-running 32-bit timer (R/W)
//   0xFFFF0004 CMP      compare value (R/W)
//   0xFFFF0008 STATUS   read:  {24'b0, occupancy[3:0], overflow, empty, full, irq_pend}
//                       write: bit0=1 clears irq_pend, bit3=1 clears overflow
//   0xFFFF000C TXDATA   write pushes writedata[7:0] into the transmit FIFO; reads 0
//   anything else       reads 0; writes are ignored
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   memwrite   store strobe from the memory stage
//   addr       byte address (addr[1:0] ignored)
//   writedata  store data
//   readdata   load data, combinational from addr and current state
//   tx_data    FIFO head byte (don't-care when tx_valid is low)
//   tx_valid   FIFO non-empty
//   tx_ready   consumer accepts the head entry this cycle
//   irq        sticky timer interrupt (irq_pend)
//
// Drain handshake: a byte leaves the FIFO at a rising edge where
// tx_valid && tx_ready. tx_valid/tx_data come only from registered state
// and never depend on tx_ready. Once tx_valid is high it stays high, with
// tx_data unchanged, until that byte is accepted.
module dmem_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);

  // Word addresses (addr >> 2) of the I/O registers.
  localparam logic [29:0] COUNT_WA  = 30'h3FFF_C000;
  localparam logic [29:0] CMP_WA    = 30'h3FFF_C001;
  localparam logic [29:0] STATUS_WA = 30'h3FFF_C002;
  localparam logic [29:0] TXDATA_WA = 30'h3FFF_C003;

  localparam logic [PW:0]   OCC_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   OCC_FULL = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic [29:0]   word_addr;
  logic          ram_sel;
  logic [AW-1:0] ram_idx;
  logic          count_wr;
  logic          cmp_wr;
  logic          status_wr;
  logic          tx_push_req;

  assign word_addr   = addr[31:2];
  assign ram_sel     = (word_addr < 30'(RAM_WORDS));
  assign ram_idx     = addr[AW+1:2];
  assign count_wr    = memwrite && (word_addr == COUNT_WA);
  assign cmp_wr      = memwrite && (word_addr == CMP_WA);
  assign status_wr   = memwrite && (word_addr == STATUS_WA);
  assign tx_push_req = memwrite && (word_addr == TXDATA_WA);

  // ---------------------------------------------------------------------
  // Word RAM (contents deliberately not reset)
  // ---------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  always_ff @(posedge clk) begin
    if (memwrite && ram_sel) begin
      ram[ram_idx] <= writedata;
    end
  end

  // ---------------------------------------------------------------------
  // Timer
  // ---------------------------------------------------------------------
  logic [31:0] count;
  logic [31:0] cmp;
  logic        irq_pend;
  logic        cmp_hit;

  // Compare on registered values, so irq rises one edge after the match cycle.
  assign cmp_hit = (count == cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= 32'd0;
      cmp      <= 32'hFFFF_FFFF;
      irq_pend <= 1'b0;
    end else begin
      count <= count_wr ? writedata : count + 32'd1;
      if (cmp_wr) begin
        cmp <= writedata;
      end
      // A set in the same cycle as a software clear takes priority.
      if (cmp_hit) begin
        irq_pend <= 1'b1;
      end else if (status_wr && writedata[0]) begin
        irq_pend <= 1'b0;
      end
    end
  end

  assign irq = irq_pend;

  // ---------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW:0]   occ;
  logic          overflow;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (occ == OCC_FULL);
  assign empty = (occ == '0);
  // full is judged at the start of the cycle, so a same-cycle pop does not
  // make room for a push.
  assign push  = tx_push_req && !full;
  assign pop   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   occ <= occ + OCC_ONE;
        2'b01:   occ <= occ - OCC_ONE;
        default: occ <= occ;
      endcase
      if (tx_push_req && full) begin
        overflow <= 1'b1;
      end else if (status_wr && writedata[3]) begin
        overflow <= 1'b0;
      end
    end
  end

  assign tx_valid = !empty;
  assign tx_data  = fifo_mem[head];

  // ---------------------------------------------------------------------
  // Load data
  // ---------------------------------------------------------------------
  logic [31:0] occ_ext;
  logic [31:0] status;

  assign occ_ext = 32'(occ);
  assign status  = {24'd0, occ_ext[3:0], overflow, empty, full, irq_pend};

  always_comb begin
    readdata = 32'd0;
    if (ram_sel) begin
      readdata = ram[ram_idx];
    end else begin
      case (word_addr)
        COUNT_WA:  readdata = count;
        CMP_WA:    readdata = cmp;
        STATUS_WA: readdata = status;
        default:   readdata = 32'd0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], occ_ext[31:4]};

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed testbench for dmem_mmio (RAM_WORDS=64, FIFO_DEPTH=4).
// Inputs change 1 ns after each rising edge; outputs are sampled before the
// next rising edge.
module tb_dmem_mmio;

  localparam logic [31:0] A_COUNT  = 32'hFFFF_0000;
  localparam logic [31:0] A_CMP    = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF_0008;
  localparam logic [31:0] A_TXDATA = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        irq;

  int total;
  int bad;

  dmem_mmio #(
    .RAM_WORDS  (64),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .irq       (irq)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, readdata, exp);
  endtask

  // One store, committed at the next rising edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    addr      = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    memwrite  = 1'b0;
    addr      = 32'd0;
    writedata = 32'd0;
    tx_ready  = 1'b0;

    // ---------------- reset ----------------
    repeat (3) tick();
    rd_chk("rst_status", A_STATUS, 32'h0000_0004);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    rd_chk("rst_cmp", A_CMP, 32'hFFFF_FFFF);
    reset = 1'b1;
    rd_chk("count_after_release", A_COUNT, 32'd0);
    rd_chk("txdata_read", A_TXDATA, 32'd0);
    tick();
    rd_chk("count_next_cycle", A_COUNT, 32'd1);

    // ---------------- RAM ----------------
    wr(32'h0000_0010, 32'h1111_1111);
    wr(32'h0000_0000, 32'hA5A5_A5A5);
    memwrite  = 1'b1;
    addr      = 32'h0000_0010;
    writedata = 32'hDEAD_BEEF;
    #1;
    chk("ram_store_cycle_old", readdata, 32'h1111_1111);
    tick();
    memwrite = 1'b0;
    rd_chk("ram_after_store", 32'h0000_0010, 32'hDEAD_BEEF);
    wr(32'h0000_1000, 32'h1234_5678);
    rd_chk("ram_oob_read", 32'h0000_1000, 32'd0);
    rd_chk("ram_oob_no_alias", 32'h0000_0000, 32'hA5A5_A5A5);

    // ---------------- timer / irq ----------------
    wr(A_CMP, 32'd20);
    wr(A_COUNT, 32'd10);
    rd_chk("count_loaded", A_COUNT, 32'd10);
    repeat (10) tick();
    rd_chk("count_at_cmp", A_COUNT, 32'd20);
    chk("irq_before_hit", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_after_hit", {31'd0, irq}, 32'd1);
    rd_chk("status_irq", A_STATUS, 32'h0000_0005);
    wr(A_STATUS, 32'd1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    wr(A_COUNT, 32'hFFFF_FFFE);
    rd_chk("count_wrap_load", A_COUNT, 32'hFFFF_FFFE);
    tick();
    rd_chk("count_max", A_COUNT, 32'hFFFF_FFFF);
    tick();
    rd_chk("count_wrapped", A_COUNT, 32'd0);

    // set beats clear in the same cycle
    wr(A_CMP, 32'd200);
    wr(A_COUNT, 32'd195);
    repeat (5) tick();
    rd_chk("count_at_200", A_COUNT, 32'd200);
    chk("irq_pre_race", {31'd0, irq}, 32'd0);
    wr(A_STATUS, 32'd1);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'd1);
    chk("irq_cleared_again", {31'd0, irq}, 32'd0);

    // ---------------- FIFO fill / overflow ----------------
    tx_ready = 1'b0;
    wr(A_TXDATA, 32'hFFFF_FF41);
    chk("push_valid_next", {31'd0, tx_valid}, 32'd1);
    chk("push_head", {24'd0, tx_data}, 32'h41);
    wr(A_TXDATA, 32'h42);
    wr(A_TXDATA, 32'h43);
    wr(A_TXDATA, 32'h44);
    rd_chk("status_full", A_STATUS, 32'h0000_0042);
    wr(A_TXDATA, 32'h45);
    rd_chk("status_overflow", A_STATUS, 32'h0000_004A);
    tx_ready = 1'b1;
    chk("drain_0", {24'd0, tx_data}, 32'h41);
    tick();
    chk("drain_1", {24'd0, tx_data}, 32'h42);
    tick();
    chk("drain_2", {24'd0, tx_data}, 32'h43);
    tick();
    chk("drain_3", {24'd0, tx_data}, 32'h44);
    chk("drain_3_valid", {31'd0, tx_valid}, 32'd1);
    tick();
    chk("drain_empty", {31'd0, tx_valid}, 32'd0);
    rd_chk("status_drained", A_STATUS, 32'h0000_000C);
    wr(A_STATUS, 32'h8);
    rd_chk("overflow_cleared", A_STATUS, 32'h0000_0004);

    // ---------------- steady occupancy 2 ----------------
    tx_ready = 1'b0;
    wr(A_TXDATA, 32'h10);
    wr(A_TXDATA, 32'h11);
    rd_chk("occ2_start", A_STATUS, 32'h0000_0020);
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("stream_head", {24'd0, tx_data}, 32'h10 + i);
      wr(A_TXDATA, 32'h12 + i);
      rd_chk("stream_occ", A_STATUS, 32'h0000_0020);
    end
    tx_ready = 1'b0;
    chk("stream_tail_head", {24'd0, tx_data}, 32'h13);

    // ---------------- full + push + pop ----------------
    wr(A_TXDATA, 32'h20);
    wr(A_TXDATA, 32'h21);
    rd_chk("refull", A_STATUS, 32'h0000_0042);
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'h22);
    tx_ready = 1'b0;
    rd_chk("full_pushpop_status", A_STATUS, 32'h0000_0038);
    chk("full_pushpop_head", {24'd0, tx_data}, 32'h14);

    // ---------------- asynchronous reset mid-run ----------------
    wr(A_STATUS, 32'h0);
    #2;
    reset = 1'b0;
    rd_chk("mid_rst_status", A_STATUS, 32'h0000_0004);
    chk("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("mid_rst_count", A_COUNT, 32'd0);
    rd_chk("mid_rst_cmp", A_CMP, 32'hFFFF_FFFF);
    tick();
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a stuck run.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-memory and memory-mapped I/O stage directly downstream of the pipelined MIPS core's memory stage. It consumes the core's `aluout`, `writedata` and `memwrite` and returns `readdata` in the same cycle. It decodes each address into one of three targets: word RAM, a 32-bit compare timer with a sticky interrupt, or a byte transmit FIFO with a valid/ready drain port.

## Interface
- `RAM_WORDS`, default 64: RAM depth in 32-bit words, power of two.
- `FIFO_DEPTH`, default 4: transmit FIFO entries, power of two, at least 2.

Ports:
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `memwrite`  in  1  store strobe from the core's memory stage.
- `addr`  in  32  byte address (core `aluout`); `addr[1:0]` ignored.
- `writedata`  in  32  store data.
- `readdata`  out  32  load data, combinational from `addr` and current state.
- `tx_data`  out  8  FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts head this cycle.
- `irq`  out  1  timer interrupt pending (sticky).

## Operation
Address map (word aligned):
- RAM: `addr < RAM_WORDS*4`. Reads are asynchronous `ram[addr>>2]`. A write stores the whole word at the edge.
- 0xFFFF0000 COUNT: R/W timer count.
- 0xFFFF0004 CMP: R/W compare value.
- 0xFFFF0008 STATUS:
  - Read: bit0 irq_pend, bit1 full, bit2 empty, bit3 overflow, bits[7:4] occupancy, others 0.
  - Write: 1 in bit0 clears irq_pend; 1 in bit3 clears overflow; other bits ignored.
- 0xFFFF000C TXDATA: write pushes `writedata[7:0]`; read returns 0.
- Any other address: read 0, write ignored, no side effects.

Timer:
- `count` increments by 1 every cycle. 0xFFFFFFFF wraps to 0.
- A COUNT write loads `writedata` instead of incrementing that cycle.
- A CMP write loads `writedata`.
- Compare uses registered values: at an edge where current `count == cmp`, irq_pend is set.
- If a set and a STATUS bit0 clear occur in the same cycle, set wins.
- `irq = irq_pend`.

FIFO:
- Circular buffer with head pointer, tail pointer and occupancy counter of width log2(FIFO_DEPTH)+1.
- A push is accepted only if `full` is low at the start of the cycle. This holds even when a pop occurs in the same cycle.
- A push while full is dropped and sets sticky overflow. If an overflow set and a STATUS bit3 clear occur in the same cycle, set wins.
- A pop occurs when `tx_valid && tx_ready`; head advances.
- A simultaneous push and pop with 0 < occupancy < DEPTH leaves occupancy unchanged.
- A simultaneous push and pop when empty: only the push takes effect, because `tx_valid` is low.
- `tx_data` always shows the head entry. Its value is don't-care when empty.
- Pointers wrap modulo FIFO_DEPTH.

Reset (asynchronous, `reset` low):
- `count`=0, `cmp`=0xFFFFFFFF, irq_pend=0, overflow=0, pointers=0, occupancy=0.
- Therefore `irq`=0, `tx_valid`=0, and STATUS reads 0x00000004.
- RAM contents are not reset.
- Reset asserted mid-operation discards FIFO contents immediately, without waiting for a clock edge.

## Timing
- Load latency 0: `readdata` is valid in the same cycle that `addr` is presented, as the core's memory stage requires.
- Stores take effect at the rising edge. A read of the same location in the store cycle returns the old value; the new value is visible the next cycle.
- Reading COUNT returns the pre-edge value. Consecutive reads in back-to-back cycles differ by 1.
- `irq` rises one edge after the cycle in which `count == cmp`.
- Pushed byte timing: written in cycle N, `tx_valid` is high from cycle N+1.
- `tx_valid`/`tx_data` depend only on registered state, never combinationally on `tx_ready`.
- Throughput: one push and one pop per cycle.

## Test plan
- Reset release, then read STATUS, COUNT, CMP, TXDATA -> 0x4, small count, 0xFFFFFFFF, 0; `irq`=0, `tx_valid`=0. Assert reset mid-run -> same values without a clock edge.
- Store 0xDEADBEEF to 0x00000010, load 0x00000010 next cycle -> 0xDEADBEEF. Load in the store cycle -> old value. Store to 0x00001000 with RAM_WORDS=64 -> no RAM change, read 0.
- Write CMP=20 and COUNT=10 -> `irq` rises when count passes 20. Write STATUS=1 -> `irq` falls. Write COUNT=0xFFFFFFFE -> wraps to 0 two cycles later.
- With `tx_ready`=0, push 0x41..0x45 -> occupancy 4, full=1, overflow=1, 0x45 dropped. Raise `tx_ready` -> 0x41,0x42,0x43,0x44 on consecutive cycles, then `tx_valid`=0.
- Occupancy 2 with `tx_ready`=1 and a push every cycle -> occupancy stays 2 and the output order is preserved. Full FIFO with a push and pop in the same cycle -> push dropped, overflow set.
- Clear irq in the same cycle that `count == cmp` -> irq_pend stays 1.
